multdiv_issue_ctrl: RTL and testbench

Sequencing stage that sits directly upstream of the multdiv unit in the execute stage. It takes a MUL/DIV instruction from X, latches and holds its operands, and issues a one-cycle `ctrl_MULT`/`ctrl_DIV` start pulse. It stalls the pipeline until multdiv reports ready, then emits a single-cycle writeback. Exceptions are redirected to `$rstatus` (r30).

---
 rtl/multdiv_issue_ctrl.sv | 105 ++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// Issue/sequencing stage in front of the multdiv unit: holds operands, pulses start,
// stalls the pipe until the result is ready, then presents a one-cycle writeback.
module multdiv_issue_ctrl #(
    parameter logic [4:0]  RSTATUS_REG   = 5'd30,
    parameter logic [31:0] MULT_EXC_CODE = 32'd4,
    parameter logic [31:0] DIV_EXC_CODE  = 32'd5
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] op_a, op_b;
    logic [4:0]  op_rd;
    logic        op_div;
    logic        latch, capture;

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: if (issue_valid && !flush) begin
                latch     = 1'b1;
                state_nxt = S_START;
            end
            S_START: state_nxt = flush ? S_IDLE : S_WAIT;
            // RDY is only trusted here; in START it still reflects the previous op.
            S_WAIT: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (md_resultRDY) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            op_a         <= '0;
            op_b         <= '0;
            op_rd        <= '0;
            op_div       <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_exception <= 1'b0;
        end else begin
            if (latch) begin
                op_a   <= issue_a;
                op_b   <= issue_b;
                op_rd  <= issue_rd;
                op_div <= issue_is_div;
            end
            if (capture) begin
                wb_exception <= md_exception;
                if (md_exception) begin
                    wb_rd   <= RSTATUS_REG;
                    wb_data <= op_div ? DIV_EXC_CODE : MULT_EXC_CODE;
                end else begin
                    wb_rd   <= op_rd;
                    wb_data <= md_result;
                end
            end
        end
    end

    assign md_operandA  = op_a;
    assign md_operandB  = op_b;
    assign md_ctrl_MULT = (state == S_START) && !op_div;
    assign md_ctrl_DIV  = (state == S_START) && op_div;
    assign wb_valid     = (state == S_DONE);
    // DONE drops stall so X advances on the same edge the writeback retires.
    assign stall = clrn && !flush &&
                   (((state == S_IDLE) && issue_valid) || (state == S_START) || (state == S_WAIT));

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl with a cycle-accurate 32-step multdiv stub.
module tb_multdiv_issue_ctrl;

    logic        clock = 1'b0;
    logic        clrn;
    logic        issue_valid, issue_is_div, flush;
    logic [31:0] issue_a, issue_b;
    logic [4:0]  issue_rd;
    logic [31:0] md_operandA, md_operandB, md_result;
    logic        md_ctrl_MULT, md_ctrl_DIV, md_exception, md_resultRDY;
    logic        stall, wb_valid, wb_exception;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    multdiv_issue_ctrl dut (
        .clock(clock), .clrn(clrn),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd), .flush(flush),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_exception(wb_exception)
    );

    // multdiv stub: counter restarts on a start pulse, RDY at count 32 and stays high
    int unsigned m_cnt = 0;
    bit          m_run = 1'b0;
    bit          m_div = 1'b0;
    always @(posedge clock) begin
        if (md_ctrl_MULT || md_ctrl_DIV) begin
            m_cnt <= 0;
            m_run <= 1'b1;
            m_div <= md_ctrl_DIV;
        end else if (m_run && m_cnt < 32) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign md_resultRDY = m_run && (m_cnt == 32);

    always_comb begin
        longint p;
        p            = longint'($signed(md_operandA)) * longint'($signed(md_operandB));
        md_result    = 32'h0;
        md_exception = 1'b0;
        if (m_div) begin
            md_exception = (md_operandB == 32'h0);
            if (!md_exception) md_result = $signed(md_operandA) / $signed(md_operandB);
        end else begin
            md_result    = p[31:0];
            md_exception = (p != longint'($signed(p[31:0])));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Call just after a posedge: that cycle is cycle 0. fc/rc = flush/reset cycle, -1 for none.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic div, input logic [4:0] rd, input int fc, input int rc,
                          input logic [4:0] e_rd, input logic [31:0] e_data, input logic e_exc);
        int n_stall = 0, n_mul = 0, n_div = 0, p_cyc = -1, n_wb = 0, wb_cyc = -1;
        logic [4:0]  g_rd = '0;
        logic [31:0] g_data = '0;
        logic        g_exc = 1'b0;
        int last = (fc >= 0 || rc >= 0) ? 40 : 35;
        issue_valid = 1'b1; issue_a = a; issue_b = b; issue_is_div = div; issue_rd = rd;
        for (int c = 0; c <= last; c++) begin
            flush = (c == fc);
            clrn  = (c != rc);
            if ((fc >= 0 && c > fc) || (rc >= 0 && c > rc)) issue_valid = 1'b0;
            @(negedge clock);
            if (stall) n_stall++;
            if (md_ctrl_MULT) begin n_mul++; p_cyc = c; end
            if (md_ctrl_DIV)  begin n_div++; p_cyc = c; end
            if (wb_valid) begin
                n_wb++; wb_cyc = c; g_rd = wb_rd; g_data = wb_data; g_exc = wb_exception;
            end
            if (c == fc) chk({name, " stall_on_flush"}, 32'(stall), 32'd0);
            if (c == rc) begin
                chk({name, " rst_opA"}, md_operandA, 32'h0);
                chk({name, " rst_outs"}, {22'h0, stall, wb_valid, wb_exception, md_ctrl_MULT,
                                          md_ctrl_DIV, wb_rd}, 32'h0);
                chk({name, " rst_wbdata"}, wb_data, 32'h0);
            end
            @(posedge clock);
            #1;
        end
        flush = 1'b0; clrn = 1'b1; issue_valid = 1'b0;
        chk({name, " n_mul"}, n_mul, (div || rc == 0 || fc == 0) ? 0 : 1);
        chk({name, " n_div"}, n_div, (div && rc != 0 && fc != 0) ? 1 : 0);
        if (fc < 0 && rc < 0) begin
            chk({name, " pulse_cyc"}, p_cyc, 1);
            chk({name, " stall_cycles"}, n_stall, 35);
            chk({name, " n_wb"}, n_wb, 1);
            chk({name, " wb_cyc"}, wb_cyc, 35);
            chk({name, " wb_rd"}, 32'(g_rd), 32'(e_rd));
            chk({name, " wb_data"}, g_data, e_data);
            chk({name, " wb_exc"}, 32'(g_exc), 32'(e_exc));
        end else begin
            chk({name, " stall_cycles"}, n_stall, (fc >= 0) ? fc : rc);
            chk({name, " n_wb"}, n_wb, 0);
        end
    endtask

    initial begin
        clrn = 1'b0; issue_valid = 1'b0; issue_is_div = 1'b0; flush = 1'b0;
        issue_a = 32'h0; issue_b = 32'h0; issue_rd = 5'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outs", {23'h0, stall, wb_valid, wb_exception, md_ctrl_MULT, wb_rd}, 32'h0);
        chk("reset_opB", md_operandB, 32'h0);
        @(posedge clock); #1;
        clrn = 1'b1;
        @(negedge clock);
        chk("post_reset_outs", {23'h0, stall, wb_valid, md_ctrl_DIV, md_ctrl_MULT, wb_rd}, 32'h0);
        chk("post_reset_wbdata", wb_data, 32'h0);

        // issue together with flush in IDLE must not latch or start
        @(posedge clock); #1;
        issue_valid = 1'b1; issue_a = 32'd123; issue_b = 32'd456; flush = 1'b1;
        @(negedge clock);
        chk("idle_flush_stall", 32'(stall), 32'd0);
        @(posedge clock); #1;
        issue_valid = 1'b0; flush = 1'b0;
        @(negedge clock);
        chk("idle_flush_nopulse", {30'h0, md_ctrl_MULT, md_ctrl_DIV}, 32'h0);
        chk("idle_flush_nolatch", md_operandA, 32'h0);
        @(posedge clock); #1;

        run_op("mul6x-7",  32'd6,        32'hFFFFFFF9, 1'b0, 5'd5, -1, -1, 5'd5,  32'hFFFFFFD6, 1'b0);
        run_op("div-100/7", 32'hFFFFFF9C, 32'd7,       1'b1, 5'd9, -1, -1, 5'd9,  32'hFFFFFFF2, 1'b0);
        run_op("div17/0",  32'd17,       32'd0,        1'b1, 5'd3, -1, -1, 5'd30, 32'd5,        1'b1);
        run_op("mulovf",   32'h7FFFFFFF, 32'd2,        1'b0, 5'd7, -1, -1, 5'd30, 32'd4,        1'b1);
        run_op("b2b_mul",  32'd3,        32'd4,        1'b0, 5'd1, -1, -1, 5'd1,  32'd12,       1'b0);
        run_op("b2b_div",  32'd20,       32'd4,        1'b1, 5'd2, -1, -1, 5'd2,  32'd5,        1'b0);
        run_op("flush10",  32'd8,        32'd8,        1'b0, 5'd4, 10, -1, 5'd0,  32'd0,        1'b0);
        chk("flush_wbdata_kept", wb_data, 32'd5);
        chk("flush_wbrd_kept", 32'(wb_rd), 32'd2);
        run_op("mul2x2",   32'd2,        32'd2,        1'b0, 5'd6, -1, -1, 5'd6,  32'd4,        1'b0);
        run_op("rst20",    32'd9,        32'd3,        1'b1, 5'd8, -1, 20, 5'd0,  32'd0,        1'b0);
        run_op("post_rst", 32'hFFFFFFFD, 32'hFFFFFFFB, 1'b0, 5'd11, -1, -1, 5'd11, 32'd15,      1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got %0d exp 0", 1);
        $fatal(1, "timeout");
    end

endmodule
